// File: rtl/ppu_bus_pkg.sv
// rtl/ppu_bus_pkg.sv - shared types and constants for the PPU video-memory bus sequencer
//
// Purpose : FSM state and bus-owner enums, bus width constants and the
//           captured-request record shared by the sequencer and its CPU latch.
// Ports   : none (package).

package ppu_bus_pkg;

   localparam int PPU_ADDR_W = 14;
   localparam int PPU_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALE    = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef enum logic {
      OWN_RENDER = 1'b0,
      OWN_CPU    = 1'b1
   } owner_t;

   typedef struct packed {
      logic                  we;
      logic [PPU_ADDR_W-1:0] addr;
      logic [PPU_DATA_W-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/ppu_bus_sequencer_if.sv
// rtl/ppu_bus_sequencer_if.sv - requester and pad signal bundle for the PPU bus sequencer
//
// Purpose : groups the phase enable, render/CPU request handshakes and the
//           multiplexed AD pad signals.
// Modports: slave  - the sequencer (consumes requests, drives the pads)
//           master - requesters and pad logic around the sequencer
// Signals : tick, render_req/addr/ack/rdata, cpu_req/we/addr/wdata/busy/done/
//           rdata/overrun, ad_out, ad_low_oe, ad_in, ale, rd_n, wr_n

interface ppu_bus_sequencer_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);

   logic              tick;
   logic              render_req;
   logic [ADDR_W-1:0] render_addr;
   logic              render_ack;
   logic [DATA_W-1:0] render_rdata;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_busy;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_overrun;
   logic [ADDR_W-1:0] ad_out;
   logic              ad_low_oe;
   logic [DATA_W-1:0] ad_in;
   logic              ale;
   logic              rd_n;
   logic              wr_n;

   modport slave (
      input  tick, render_req, render_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ad_in,
      output render_ack, render_rdata, cpu_busy, cpu_done, cpu_rdata, cpu_overrun,
             ad_out, ad_low_oe, ale, rd_n, wr_n
   );

   modport master (
      output tick, render_req, render_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ad_in,
      input  render_ack, render_rdata, cpu_busy, cpu_done, cpu_rdata, cpu_overrun,
             ad_out, ad_low_oe, ale, rd_n, wr_n
   );

endinterface

// File: rtl/ppu_cpu_req_latch.sv
// rtl/ppu_cpu_req_latch.sv - CPU $2007 request buffer, busy/overrun flags and starvation counter
//
// Purpose : holds one CPU access from capture until completion and counts
//           render grants made while it waits.
// Ports   : i_clk, i_rst_n          clock, async active-low reset
//           i_cpu_req/we/addr/wdata CPU request pulse and its payload
//           i_grant_cpu             sequencer granted the bus to the CPU
//           i_grant_render          sequencer granted the bus to render
//           i_cpu_complete          CPU access finished on the bus
//           o_req                   captured access
//           o_pending               captured but not yet granted
//           o_busy                  captured and not yet complete
//           o_overrun               sticky: request dropped while busy
//           o_wait_max              render grants reached CPU_MAX_WAIT

module ppu_cpu_req_latch
   import ppu_bus_pkg::*;
#(
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cpu_req,
   input  logic                  i_cpu_we,
   input  logic [PPU_ADDR_W-1:0] i_cpu_addr,
   input  logic [PPU_DATA_W-1:0] i_cpu_wdata,
   input  logic                  i_grant_cpu,
   input  logic                  i_grant_render,
   input  logic                  i_cpu_complete,
   output bus_req_t              o_req,
   output logic                  o_pending,
   output logic                  o_busy,
   output logic                  o_overrun,
   output logic                  o_wait_max
);

   localparam int          WAIT_W   = 8;
   localparam [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

   bus_req_t    r_req;
   logic        r_pending;
   logic        r_busy;
   logic        r_overrun;
   logic [WAIT_W-1:0] r_wait;

   // Capture needs busy=0 while grant/complete need busy=1, so the
   // updates below never collide on the same flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_req     <= '0;
         r_pending <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_wait    <= '0;
      end else begin
         if (i_cpu_req) begin
            if (r_busy) begin
               r_overrun <= 1'b1;
            end else begin
               r_req     <= '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
               r_pending <= 1'b1;
               r_busy    <= 1'b1;
            end
         end
         if (i_grant_cpu) begin
            r_pending <= 1'b0;
         end
         if (i_cpu_complete) begin
            r_busy <= 1'b0;
         end
         // Only render grants that overtake a waiting CPU access count.
         if (i_grant_cpu) begin
            r_wait <= '0;
         end else if (i_grant_render && r_pending && (r_wait != WAIT_MAX)) begin
            r_wait <= r_wait + 1'b1;
         end
      end
   end

   assign o_req      = r_req;
   assign o_pending  = r_pending;
   assign o_busy     = r_busy;
   assign o_overrun  = r_overrun;
   assign o_wait_max = (r_wait == WAIT_MAX);

endmodule

// File: rtl/ppu_bus_sequencer.sv
// rtl/ppu_bus_sequencer.sv - two-phase PPU video-memory bus sequencer with render/CPU arbitration
//
// Purpose : runs every access as ALE phase then strobe phase, arbitrates
//           render (priority) against CPU (bounded wait), returns read data.
// Ports   : CLK   PPU core clock
//           RST   async active-low reset
//           bus   ppu_bus_sequencer_if.slave (tick, request handshakes, AD pads)

module ppu_bus_sequencer
   import ppu_bus_pkg::*;
#(
   parameter int ADDR_W       = PPU_ADDR_W,
   parameter int DATA_W       = PPU_DATA_W,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic                CLK,
   input  logic                RST,
   ppu_bus_sequencer_if.slave  bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   owner_t            r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_render_ack;
   logic [DATA_W-1:0] r_render_rdata;
   logic              r_cpu_done;
   logic [DATA_W-1:0] r_cpu_rdata;

   bus_req_t          w_cpu_req;
   logic              w_pending;
   logic              w_busy;
   logic              w_overrun;
   logic              w_wait_max;
   logic              w_decide;
   logic              w_grant_cpu;
   logic              w_grant_render;
   logic              w_complete;
   logic              w_cpu_complete;

   logic              w_ale;
   logic              w_rd_n;
   logic              w_wr_n;
   logic              w_ad_low_oe;
   logic [ADDR_W-1:0] w_ad_out;

   ppu_cpu_req_latch #(
      .CPU_MAX_WAIT (CPU_MAX_WAIT)
   ) u_cpu_latch (
      .i_clk          (CLK),
      .i_rst_n        (RST),
      .i_cpu_req      (bus.cpu_req),
      .i_cpu_we       (bus.cpu_we),
      .i_cpu_addr     (bus.cpu_addr),
      .i_cpu_wdata    (bus.cpu_wdata),
      .i_grant_cpu    (w_grant_cpu),
      .i_grant_render (w_grant_render),
      .i_cpu_complete (w_cpu_complete),
      .o_req          (w_cpu_req),
      .o_pending      (w_pending),
      .o_busy         (w_busy),
      .o_overrun      (w_overrun),
      .o_wait_max     (w_wait_max)
   );

   // Decisions happen from IDLE or on the tick that ends ACCESS, which
   // lets a new grant go straight to ALE with no idle bubble.
   assign w_decide       = bus.tick && ((r_state == IDLE) || (r_state == ACCESS));
   assign w_grant_cpu    = w_decide && w_pending && (!bus.render_req || w_wait_max);
   assign w_grant_render = w_decide && !w_grant_cpu && bus.render_req;
   assign w_complete     = bus.tick && (r_state == ACCESS);
   assign w_cpu_complete = w_complete && (r_owner == OWN_CPU);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Strobes decode straight from state so an async reset releases them
   // immediately; rd_n/wr_n are exclusive by construction of r_we.
   always_comb begin
      w_state_nxt = r_state;
      w_ale       = 1'b0;
      w_rd_n      = 1'b1;
      w_wr_n      = 1'b1;
      w_ad_low_oe = 1'b0;
      w_ad_out    = '0;
      case (r_state)
         IDLE: begin
            if (w_grant_cpu || w_grant_render) begin
               w_state_nxt = ALE;
            end
         end
         ALE: begin
            w_ale       = 1'b1;
            w_ad_out    = r_addr;
            w_ad_low_oe = 1'b1;
            if (bus.tick) begin
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (r_we) begin
               w_wr_n      = 1'b0;
               w_ad_low_oe = 1'b1;
               w_ad_out    = {r_addr[ADDR_W-1:DATA_W], r_wdata};
            end else begin
               // Low byte is undriven (oe=0) so its value is irrelevant.
               w_rd_n   = 1'b0;
               w_ad_out = r_addr;
            end
            if (bus.tick) begin
               w_state_nxt = (w_grant_cpu || w_grant_render) ? ALE : IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Granted access is frozen here for the ALE and ACCESS phases.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_owner <= OWN_RENDER;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant_cpu) begin
         r_owner <= OWN_CPU;
         r_we    <= w_cpu_req.we;
         r_addr  <= w_cpu_req.addr;
         r_wdata <= w_cpu_req.wdata;
      end else if (w_grant_render) begin
         r_owner <= OWN_RENDER;
         r_we    <= 1'b0;
         r_addr  <= bus.render_addr;
         r_wdata <= '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_render_ack   <= 1'b0;
         r_render_rdata <= '0;
         r_cpu_done     <= 1'b0;
         r_cpu_rdata    <= '0;
      end else begin
         r_render_ack <= w_complete && (r_owner == OWN_RENDER);
         r_cpu_done   <= w_cpu_complete;
         if (w_complete && (r_owner == OWN_RENDER)) begin
            r_render_rdata <= bus.ad_in;
         end
         if (w_cpu_complete && !r_we) begin
            r_cpu_rdata <= bus.ad_in;
         end
      end
   end

   assign bus.render_ack   = r_render_ack;
   assign bus.render_rdata = r_render_rdata;
   assign bus.cpu_busy     = w_busy;
   assign bus.cpu_done     = r_cpu_done;
   assign bus.cpu_rdata    = r_cpu_rdata;
   assign bus.cpu_overrun  = w_overrun;
   assign bus.ad_out       = w_ad_out;
   assign bus.ad_low_oe    = w_ad_low_oe;
   assign bus.ale          = w_ale;
   assign bus.rd_n         = w_rd_n;
   assign bus.wr_n         = w_wr_n;

endmodule

// File: doc/ppu_bus_sequencer.md
Name: ppu_bus_sequencer

Overview:
- Owns the PPU external video-memory bus (multiplexed 14-bit AD, ALE, RD, WR) and shares it between two requesters: the render fetch engine (background/sprite/dummy fetches) and CPU $2007 data-port accesses.
- Sequences every access as a fixed two-phase cycle (address-latch phase, then strobe phase) and returns read data.
- Render has priority; a bounded-wait rule guarantees CPU progress.
- Sits between the register/render control logic and the PPU_AD pad drivers.

Parameters:
- ADDR_W, 14, video address width.
- DATA_W, 8, data width (multiplexed onto AD[DATA_W-1:0]).
- CPU_MAX_WAIT, 8, max consecutive render grants while a CPU access is pending; range 1..255.

Ports:
- CLK  in  1  PPU core clock.
- RST  in  1  asynchronous active-low reset.
- tick  in  1  bus-phase enable; state advances only on CLK edges with tick=1.
- render_req  in  1  render fetch request; held until render_ack.
- render_addr  in  ADDR_W  render fetch address; stable while render_req=1.
- render_ack  out  1  one-CLK pulse: render read complete, render_rdata valid.
- render_rdata  out  DATA_W  render read data; holds until next render completion.
- cpu_req  in  1  one-CLK pulse: start a CPU access.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  sampled with cpu_req.
- cpu_wdata  in  DATA_W  sampled with cpu_req.
- cpu_busy  out  1  CPU access pending or in flight.
- cpu_done  out  1  one-CLK pulse on CPU access completion.
- cpu_rdata  out  DATA_W  CPU read data; holds until next CPU read completion.
- cpu_overrun  out  1  sticky: cpu_req arrived while cpu_busy=1; cleared only by reset.
- ad_out  out  ADDR_W  value driven onto AD.
- ad_low_oe  out  1  output enable for AD[DATA_W-1:0]; upper bits always driven.
- ad_in  in  DATA_W  AD[DATA_W-1:0] pad input.
- ale  out  1  address latch enable, active high.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.

Behaviour:
- Reset (async, RST=0):
  - state IDLE.
  - ale=0, rd_n=1, wr_n=1, ad_low_oe=0, ad_out=0.
  - render_ack=0, cpu_done=0, cpu_busy=0, cpu_overrun=0.
  - render_rdata=0, cpu_rdata=0, wait counter 0, pending buffer empty.
  - Reset mid-access aborts it: strobes release immediately and no ack/done is generated.
- CPU capture: cpu_req with cpu_busy=0 latches we/addr/wdata into the pending buffer; cpu_busy=1 from the next CLK.
  - cpu_req with cpu_busy=1 is ignored and sets cpu_overrun.
  - cpu_req is captured regardless of tick.
- Arbitration runs on tick edges in IDLE or at the end of ACCESS:
  - CPU pending and (render_req=0 or wait counter = CPU_MAX_WAIT) -> grant CPU, clear counter.
  - Otherwise render_req -> grant render; counter increments only if CPU pending, saturating at CPU_MAX_WAIT.
  - Otherwise go to IDLE.
  - A cpu_req arriving in the same CLK as a grant decision is not eligible until the next decision.
- FSM states: IDLE, ALE, ACCESS.
  - IDLE: all strobes inactive, ad_low_oe=0; grant -> ALE.
  - ALE: ale=1, ad_out=granted addr, ad_low_oe=1; tick -> ACCESS.
  - ACCESS read: ale=0, ad_out[ADDR_W-1:DATA_W]=addr high, ad_low_oe=0, rd_n=0.
  - ACCESS write: ale=0, wr_n=0, ad_low_oe=1, ad_out[DATA_W-1:0]=wdata.
  - At the ACCESS-ending tick: sample ad_in for reads, pulse render_ack or cpu_done for one CLK, clear cpu_busy on CPU completion.
  - Then arbitrate: grant -> ALE (back-to-back, no IDLE bubble), else IDLE.
- Timing:
  - Latency: decision tick -> ack/done high after the 2nd following tick.
  - Throughput: one access per 2 ticks.
- Strobe integrity: rd_n and wr_n are never low simultaneously, and never low during ALE.
- Render writes do not exist; render accesses are always reads.
- Address wrap: none; addresses are passed unmodified, and mirroring and palette decode are the caller's job.

Decomposition:
- Package ppu_bus_pkg:
  - state enum {IDLE, ALE, ACCESS}
  - owner enum {OWN_RENDER, OWN_CPU}
  - PPU_ADDR_W / PPU_DATA_W constants
  - packed struct bus_req_t {we, addr, wdata}
- Sub-module ppu_cpu_req_latch: pending buffer, busy/overrun flags, starvation counter.
- FSM and strobes stay in the top.

Test Plan:
- Reset then tick every CLK, render_req=1, addr=0x2000, ad_in=0x5A -> ALE with ad_out=0x2000, then rd_n=0 with ad_low_oe=0, render_ack pulse with render_rdata=0x5A.
- cpu_req write addr=0x2105 data=0xC3, no render -> ALE ad_out=0x2105, then wr_n=0 with ad_out[7:0]=0xC3 and ad_low_oe=1, cpu_done pulse, cpu_busy falls.
- render_req held continuously plus cpu read pending, CPU_MAX_WAIT=8 -> exactly 8 render acks, then the CPU access, then render resumes; no IDLE gaps.
- Second cpu_req while busy -> cpu_overrun=1 stays set, the first access completes with its original address, the second is never issued.
- RST low during ACCESS read -> rd_n=1 and ale=0 asynchronously, no ack; after release the FSM is IDLE and the next request runs normally.
- tick held low 5 CLKs mid-ALE -> outputs frozen; progress resumes on the next tick; strobes are never low together throughout.
